// File: rtl/captura_operandos_n.sv
// ---------------------------------------------------------------------------
// captura_operandos_n
//
// Captures two operands, A then B, typed on a keypad one 4-bit key code at a
// time. It accumulates them into binary values. Once both operands are
// committed, they are held with ready_operands high until the consumer
// acknowledges them.
//
// Entry modes (parameter MODO_DEC):
//   0 : hex entry. Every code 0x0-0xF is a digit and acc = (acc << 4) | key.
//   1 : decimal entry. Codes 0x0-0x9 are digits and acc = acc*10 + key.
//       The remaining codes have these meanings:
//         0xA ENTER   - commits the operand early (ignored with no digits)
//         0xB CLR_OP  - clears the operand being typed
//         0xC CLR_ALL - back to operand A, clears A_bin and B_bin as well
//         0xD-0xF     - ignored
// An operand is committed automatically when its DIGITS-th digit arrives.
//
// Optional feature, macro CAPTURA_TIMEOUT_EN:
//   An abandoned entry is aborted after TIMEOUT_CYC idle cycles. The abort
//   returns to operand A and pulses timeout_err for one cycle.
//   A_bin and B_bin keep their values.
//   When the macro is not defined there is no counter, timeout_err is 0, and
//   entry waits forever.
//
// Parameters:
//   DIGITS      - max keypad digits per operand (1..8), W = 4*DIGITS
//   MODO_DEC    - 0 hex entry, 1 decimal entry
//   TIMEOUT_CYC - inactivity limit in clk cycles (timeout build only)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   tecla[3:0]     in   key code from the keypad decoder
//   tecla_valida   in   one-cycle strobe qualifying tecla
//   consumir       in   consumer acknowledge, releases READY
//   A_bin[W-1:0]   out  committed operand A
//   B_bin[W-1:0]   out  committed operand B
//   ready_operands out  A_bin/B_bin valid and held
//   op_sel         out  1 while capturing operand B
//   parcial[W-1:0] out  running accumulator (display feed)
//   timeout_err    out  one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module captura_operandos_n #(
    parameter int DIGITS      = 2,
    parameter int MODO_DEC    = 0,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            tecla,
    input  logic                  tecla_valida,
    input  logic                  consumir,
    output logic [4*DIGITS-1:0]   A_bin,
    output logic [4*DIGITS-1:0]   B_bin,
    output logic                  ready_operands,
    output logic                  op_sel,
    output logic [4*DIGITS-1:0]   parcial,
    output logic                  timeout_err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    // Count value seen while the last digit of an operand is being accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        CAP_A = 2'd0,
        CAP_B = 2'd1,
        READY = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    acc, acc_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [W-1:0]    a_nx, b_nx;
    logic [W-1:0]    acc_dig;
    logic [W-1:0]    commit_val;
    logic            commit;
    logic            is_digit, is_enter, is_clr_op, is_clr_all;
    logic            tmo_hit;

    // One accumulation step. The decimal path uses two shifts and an add
    // instead of a multiplier. The result wraps to W bits like the hex path.
    function automatic logic [W-1:0] acc_step(input logic [W-1:0] a,
                                              input logic [3:0]   d);
        if (MODO_DEC != 0)
            return (a << 3) + (a << 1) + W'(d);
        else
            return (a << 4) | W'(d);
    endfunction

    // Key classification. In hex mode every code is a digit, so the command
    // decodes can never fire.
    always_comb begin
        is_digit   = (MODO_DEC == 0) || (tecla <= 4'd9);
        is_enter   = (MODO_DEC != 0) && (tecla == 4'hA);
        is_clr_op  = (MODO_DEC != 0) && (tecla == 4'hB);
        is_clr_all = (MODO_DEC != 0) && (tecla == 4'hC);
        acc_dig    = acc_step(acc, tecla);
    end

    // Next-state and next-data logic.
    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        cnt_nx     = cnt;
        a_nx       = A_bin;
        b_nx       = B_bin;
        commit     = 1'b0;
        commit_val = acc;

        if (state == READY) begin
            // Keys are ignored here. The acknowledge also swallows any key
            // that arrives in the same cycle.
            if (consumir) begin
                state_nx = CAP_A;
                acc_nx   = '0;
                cnt_nx   = '0;
            end
        end else if (tecla_valida) begin
            if (is_digit) begin
                if (cnt == CNT_LAST) begin
                    commit     = 1'b1;
                    commit_val = acc_dig;
                end else begin
                    acc_nx = acc_dig;
                    cnt_nx = cnt + CW'(1);
                end
            end else if (is_enter) begin
                if (cnt != '0)
                    commit = 1'b1;
            end else if (is_clr_op) begin
                acc_nx = '0;
                cnt_nx = '0;
            end else if (is_clr_all) begin
                state_nx = CAP_A;
                acc_nx   = '0;
                cnt_nx   = '0;
                a_nx     = '0;
                b_nx     = '0;
            end
        end

        if (commit) begin
            acc_nx = '0;
            cnt_nx = '0;
            if (state == CAP_A) begin
                a_nx     = commit_val;
                state_nx = CAP_B;
            end else begin
                b_nx     = commit_val;
                state_nx = READY;
            end
        end

        // The abort only happens in a cycle with no accepted key, so it
        // never collides with a commit.
        if (tmo_hit) begin
            state_nx = CAP_A;
            acc_nx   = '0;
            cnt_nx   = '0;
        end
    end

    // State and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAP_A;
            acc   <= '0;
            cnt   <= '0;
            A_bin <= '0;
            B_bin <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            A_bin <= a_nx;
            B_bin <= b_nx;
        end
    end

    assign ready_operands = (state == READY);
    assign op_sel         = (state == CAP_B);
    assign parcial        = acc;

`ifdef CAPTURA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmr;
    logic          tmr_active;
    logic          key_ok;

    // An entry is "in progress" once A has a digit, or at any time in B.
    // An accepted key is one with a defined meaning in the current mode.
    always_comb begin
        tmr_active = ((state == CAP_A) && (cnt != '0)) || (state == CAP_B);
        key_ok     = tecla_valida && (state != READY) &&
                     (is_digit || is_enter || is_clr_op || is_clr_all);
        tmo_hit    = tmr_active && !key_ok && (tmr == TMR_LAST);
    end

    // Inactivity counter
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (!tmr_active || key_ok || tmo_hit)
                tmr <= '0;
            else
                tmr <= tmr + TW'(1);
        end
    end
`else
    // Without the timeout feature, TIMEOUT_CYC has no effect and entry
    // waits indefinitely.
    assign tmo_hit     = 1'b0;
    assign timeout_err = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_captura_operandos_n.sv
// ---------------------------------------------------------------------------
// tb_captura_operandos_n
//
// Drives two instances of captura_operandos_n:
//   - hex entry, DIGITS=2
//   - decimal entry, DIGITS=3
// Both instances use TIMEOUT_CYC=20, which only matters when the design is
// built with CAPTURA_TIMEOUT_EN.
//
// Each instance has a reference model that keeps the typed digits in a list.
// The model computes the operand value positionally from that list.
// All outputs of both instances are compared every cycle, after a sequence of
// directed scenarios and then a randomized run.
// ---------------------------------------------------------------------------
module tb_captura_operandos_n;

    localparam int TMO = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, index 0 = hex instance, 1 = decimal instance
    logic       rs[2];
    logic       tv[2];
    logic       cs[2];
    logic [3:0] tk[2];

    logic [7:0]  a_h, b_h, p_h;
    logic        r_h, o_h, t_h;
    logic [11:0] a_d, b_d, p_d;
    logic        r_d, o_d, t_d;

    captura_operandos_n #(.DIGITS(2), .MODO_DEC(0), .TIMEOUT_CYC(TMO)) u_hex (
        .clk(clk), .rst(rs[0]), .tecla(tk[0]), .tecla_valida(tv[0]),
        .consumir(cs[0]), .A_bin(a_h), .B_bin(b_h), .ready_operands(r_h),
        .op_sel(o_h), .parcial(p_h), .timeout_err(t_h)
    );

    captura_operandos_n #(.DIGITS(3), .MODO_DEC(1), .TIMEOUT_CYC(TMO)) u_dec (
        .clk(clk), .rst(rs[1]), .tecla(tk[1]), .tecla_valida(tv[1]),
        .consumir(cs[1]), .A_bin(a_d), .B_bin(b_d), .ready_operands(r_d),
        .op_sel(o_d), .parcial(p_d), .timeout_err(t_d)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = entering A, 1 = entering B, 2 = operands ready
    int m_ph[2];
    int m_n[2];
    int m_digs[2][8];
    int m_a[2];
    int m_b[2];
    int m_to[2];
    int m_idle[2];

    function automatic int m_digits(int i);
        return (i == 1) ? 3 : 2;
    endfunction

    // Value of the digits typed so far, most significant first
    function automatic int m_value(int i);
        int base = (i == 1) ? 10 : 16;
        int v = 0;
        for (int j = 0; j < m_n[i]; j++)
            v = v * base + m_digs[i][j];
        return v % (1 << (4 * m_digits(i)));
    endfunction

    task automatic m_commit(int i);
        int v = m_value(i);
        if (m_ph[i] == 0) begin
            m_a[i]  = v;
            m_ph[i] = 1;
        end else begin
            m_b[i]  = v;
            m_ph[i] = 2;
        end
        m_n[i] = 0;
    endtask

    task automatic model_edge(int i);
        bit dec = (i == 1);
        bit accepted = 0;
        int k = int'(tk[i]);
        int ph0 = m_ph[i];
        int n0 = m_n[i];
        m_to[i] = 0;
        if (rs[i]) begin
            m_ph[i] = 0; m_n[i] = 0; m_a[i] = 0; m_b[i] = 0; m_idle[i] = 0;
            return;
        end
        if (m_ph[i] == 2) begin
            if (cs[i]) begin
                m_ph[i] = 0;
                m_n[i]  = 0;
            end
        end else if (tv[i]) begin
            if (!dec || k <= 9) begin
                accepted = 1;
                m_digs[i][m_n[i]] = k;
                m_n[i]++;
                if (m_n[i] == m_digits(i)) m_commit(i);
            end else if (k == 10) begin
                accepted = 1;
                if (m_n[i] >= 1) m_commit(i);
            end else if (k == 11) begin
                accepted = 1;
                m_n[i] = 0;
            end else if (k == 12) begin
                accepted = 1;
                m_ph[i] = 0; m_n[i] = 0; m_a[i] = 0; m_b[i] = 0;
            end
        end
`ifdef CAPTURA_TIMEOUT_EN
        if (accepted) begin
            m_idle[i] = 0;
        end else if ((ph0 == 0 && n0 > 0) || ph0 == 1) begin
            m_idle[i]++;
            if (m_idle[i] == TMO) begin
                m_ph[i] = 0; m_n[i] = 0; m_to[i] = 1; m_idle[i] = 0;
            end
        end else begin
            m_idle[i] = 0;
        end
`else
        if (accepted && ph0 < 0 && n0 < 0) m_idle[i] = 0;
`endif
    endtask

    task automatic compare_all();
        chk("hex A_bin", 32'(a_h), m_a[0]);
        chk("hex B_bin", 32'(b_h), m_b[0]);
        chk("hex ready", 32'(r_h), (m_ph[0] == 2));
        chk("hex op_sel", 32'(o_h), (m_ph[0] == 1));
        chk("hex parcial", 32'(p_h), m_value(0));
        chk("hex timeout", 32'(t_h), m_to[0]);
        chk("dec A_bin", 32'(a_d), m_a[1]);
        chk("dec B_bin", 32'(b_d), m_b[1]);
        chk("dec ready", 32'(r_d), (m_ph[1] == 2));
        chk("dec op_sel", 32'(o_d), (m_ph[1] == 1));
        chk("dec parcial", 32'(p_d), m_value(1));
        chk("dec timeout", 32'(t_d), m_to[1]);
    endtask

    // One clock: inputs already set, model follows the edge, outputs sampled
    // 1 time unit later, then strobes drop back to idle.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        compare_all();
        for (int i = 0; i < 2; i++) begin
            rs[i] = 1'b0; tv[i] = 1'b0; cs[i] = 1'b0;
        end
    endtask

    task automatic press(int i, logic [3:0] k);
        tk[i] = k;
        tv[i] = 1'b1;
        tick();
    endtask

    task automatic consume(int i);
        cs[i] = 1'b1;
        tick();
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 2; i++) begin
            rs[i] = 1'b1; tv[i] = 1'b0; cs[i] = 1'b0; tk[i] = 4'h0;
            m_ph[i] = 0; m_n[i] = 0; m_a[i] = 0; m_b[i] = 0; m_to[i] = 0; m_idle[i] = 0;
        end
        tick();
        chk("rst hex A", 32'(a_h), 0);
        chk("rst hex ready", 32'(r_h), 0);
        chk("rst dec op_sel", 32'(o_d), 0);

        // Hex 4,2,0,8
        press(0, 4'h4);
        chk("hex op_sel after 4", 32'(o_h), 0);
        press(0, 4'h2);
        chk("hex op_sel after 2", 32'(o_h), 1);
        press(0, 4'h0);
        press(0, 4'h8);
        chk("hex A 42", 32'(a_h), 32'h42);
        chk("hex B 08", 32'(b_h), 32'h08);
        chk("hex ready after 8", 32'(r_h), 1);

        // Keys in READY are dropped; consumir wins over a simultaneous key
        press(0, 4'h5);
        chk("hex ready holds", 32'(r_h), 1);
        chk("hex A held", 32'(a_h), 32'h42);
        tk[0] = 4'h3; tv[0] = 1'b1; cs[0] = 1'b1;
        tick();
        chk("hex ready cleared", 32'(r_h), 0);
        chk("hex parcial after consume", 32'(p_h), 0);
        chk("hex B kept", 32'(b_h), 32'h08);
        press(0, 4'h1);
        press(0, 4'h2);
        chk("hex A 12 fresh", 32'(a_h), 32'h12);

        // Reset in the middle of operand B
        press(0, 4'h3);
        rs[0] = 1'b1;
        tick();
        chk("mid rst A", 32'(a_h), 0);
        chk("mid rst parcial", 32'(p_h), 0);
        chk("mid rst op_sel", 32'(o_h), 0);
        press(0, 4'h4); press(0, 4'h2); press(0, 4'h0); press(0, 4'h8);
        chk("post rst A", 32'(a_h), 32'h42);
        chk("post rst B", 32'(b_h), 32'h08);

        // Decimal 1,2,ENTER,7,5,0 then 9 x6
        press(1, 4'h1); press(1, 4'h2); press(1, 4'hA);
        press(1, 4'h7); press(1, 4'h5); press(1, 4'h0);
        chk("dec A 12", 32'(a_d), 12);
        chk("dec B 750", 32'(b_d), 750);
        chk("dec ready", 32'(r_d), 1);
        consume(1);
        for (int j = 0; j < 6; j++) press(1, 4'h9);
        chk("dec A 999", 32'(a_d), 999);
        chk("dec B 999", 32'(b_d), 999);

        // Decimal 3,CLR_OP,4,ENTER,5,CLR_ALL,6,ENTER,7,ENTER
        consume(1);
        press(1, 4'h3); press(1, 4'hB); press(1, 4'h4); press(1, 4'hA);
        chk("dec clr_op A 4", 32'(a_d), 4);
        press(1, 4'h5); press(1, 4'hC);
        chk("dec clr_all A 0", 32'(a_d), 0);
        chk("dec clr_all op_sel", 32'(o_d), 0);
        press(1, 4'h6); press(1, 4'hA); press(1, 4'h7); press(1, 4'hA);
        chk("dec final A 6", 32'(a_d), 6);
        chk("dec final B 7", 32'(b_d), 7);
        chk("dec final ready", 32'(r_d), 1);
        consume(1);

`ifdef CAPTURA_TIMEOUT_EN
        // One digit, then idle: exactly one timeout pulse
        rs[0] = 1'b1;
        tick();
        press(0, 4'h5);
        pulses = 0;
        for (int j = 0; j < TMO + 5; j++) begin
            tick();
            pulses += int'(t_h);
        end
        chk("tmo pulses", pulses, 1);
        chk("tmo parcial", 32'(p_h), 0);
        // A key 19 cycles after the previous one keeps the entry alive
        press(0, 4'h5);
        pulses = 0;
        for (int j = 0; j < TMO - 2; j++) begin
            tick();
            pulses += int'(t_h);
        end
        press(0, 4'h6);
        pulses += int'(t_h);
        chk("tmo prevented", pulses, 0);
        chk("tmo prevented A", 32'(a_h), 32'h56);
`endif

        // Randomized run on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rs[i] = ($urandom_range(0, 199) == 0);
                tv[i] = ($urandom_range(0, 9) < 4);
                cs[i] = ($urandom_range(0, 9) == 0);
                tk[i] = 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
